// File: rtl/bus_phase_sequencer_pkg.sv
// bus_seq_pkg: shared states, bus phase codes and constants for the bus phase sequencer
package bus_seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ALO, S_AHI, S_DATA, S_DONE} state_e;
  typedef enum logic [1:0] {PH_IDLE = 2'b00, PH_ALO = 2'b01, PH_AHI = 2'b10, PH_DATA = 2'b11} phase_e;
  localparam logic [7:0] TIMEOUT_DATA = 8'hFF;
  function automatic phase_e phase_of(state_e s);
    return s == S_ALO ? PH_ALO : s == S_AHI ? PH_AHI : s == S_DATA ? PH_DATA : PH_IDLE;
  endfunction
endpackage

// File: rtl/bus_phase_sequencer_if.sv
// bus_phase_sequencer_if: core-side access signals and 8-bit pin bus of the sequencer
interface bus_phase_sequencer_if;
  logic [15:0] cpu_ab;
  logic [7:0]  cpu_do;
  logic        cpu_we;
  logic        cpu_req;
  logic [7:0]  cpu_di;
  logic        cpu_rdy;
  logic [7:0]  bus_out;
  logic [7:0]  bus_in;
  logic        bus_oe;
  logic [1:0]  bus_phase;
  logic        bus_strobe;
  logic        ext_ack;
  logic        timeout;
  modport slave (
    input  cpu_ab, cpu_do, cpu_we, cpu_req, bus_in, ext_ack,
    output cpu_di, cpu_rdy, bus_out, bus_oe, bus_phase, bus_strobe, timeout
  );
  modport master (
    output cpu_ab, cpu_do, cpu_we, cpu_req, bus_in, ext_ack,
    input  cpu_di, cpu_rdy, bus_out, bus_oe, bus_phase, bus_strobe, timeout
  );
endinterface

// File: rtl/bus_phase_sequencer_timer.sv
// seq_wait_timer: loadable down-counter whose terminal flag marks the last cycle of a hold
module seq_wait_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);
  logic [W-1:0] cnt;
  // load on phase entry, then count down and park at zero
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign tc = cnt == '0;
endmodule

// File: rtl/bus_phase_sequencer.sv
// bus_phase_sequencer: serialises core accesses into addr-lo/addr-hi/data phases on an 8-bit bus
module bus_phase_sequencer
  import bus_seq_pkg::*;
#(
  parameter int SETUP_CYCLES = 1,
  parameter int ACK_TIMEOUT  = 15
) (
  input logic clk,
  input logic rst_n,
  bus_phase_sequencer_if.slave bus
);
  localparam int MAXC = SETUP_CYCLES > ACK_TIMEOUT ? SETUP_CYCLES : ACK_TIMEOUT;
  localparam int W = $clog2(MAXC + 1);
  localparam logic [W-1:0] SETUP_LD = W'(SETUP_CYCLES - 1);
  localparam logic [W-1:0] ACK_LD = ACK_TIMEOUT == 0 ? '0 : W'(ACK_TIMEOUT - 1);
  state_e state, state_n;
  logic [15:0] ab, ab_sel;
  logic [7:0] wdata;
  logic we, load, tc, acked, expired;
  logic [W-1:0] load_val;
  seq_wait_timer #(.W(W)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .load_val(load_val),
    .tc(tc)
  );
  assign acked = state == S_DATA && bus.ext_ack;
  assign expired = state == S_DATA && ACK_TIMEOUT != 0 && tc && !bus.ext_ack;
  assign ab_sel = state == S_IDLE ? bus.cpu_ab : ab;
  // next state and timer reload on each phase entry
  always_comb begin
    state_n = state;
    load = 1'b0;
    load_val = SETUP_LD;
    case (state)
      S_IDLE: if (bus.cpu_req) begin state_n = S_ALO; load = 1'b1; end
      S_ALO:  if (tc) begin state_n = S_AHI; load = 1'b1; end
      S_AHI:  if (tc) begin state_n = S_DATA; load = 1'b1; load_val = ACK_LD; end
      S_DATA: if (acked || expired) state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk)
    if (!rst_n) state <= S_IDLE;
    else state <= state_n;
  // latch the access only when it is accepted in IDLE
  always_ff @(posedge clk)
    if (!rst_n) begin
      ab <= '0;
      wdata <= '0;
      we <= 1'b0;
    end else if (state == S_IDLE && bus.cpu_req) begin
      ab <= bus.cpu_ab;
      wdata <= bus.cpu_do;
      we <= bus.cpu_we;
    end
  // outputs are registered from the next state so they line up with the phase being entered
  always_ff @(posedge clk)
    if (!rst_n) begin
      bus.cpu_di <= '0;
      bus.cpu_rdy <= 1'b0;
      bus.bus_out <= '0;
      bus.bus_oe <= 1'b0;
      bus.bus_phase <= PH_IDLE;
      bus.bus_strobe <= 1'b0;
      bus.timeout <= 1'b0;
    end else begin
      bus.bus_phase <= phase_of(state_n);
      bus.bus_oe <= state_n == S_ALO || state_n == S_AHI || (state_n == S_DATA && we);
      bus.bus_out <= state_n == S_ALO ? ab_sel[7:0] : state_n == S_AHI ? ab_sel[15:8] :
                     (state_n == S_DATA && we) ? wdata : 8'h00;
      bus.bus_strobe <= state_n == S_DATA;
      bus.cpu_rdy <= state_n == S_DONE;
      if ((acked || expired) && !we) bus.cpu_di <= acked ? bus.bus_in : TIMEOUT_DATA;
      if (expired) bus.timeout <= 1'b1;
    end
endmodule

// File: tb/tb_bus_phase_sequencer.sv
// tb_bus_phase_sequencer: randomized and directed checks of three sequencer configurations
module tb_bus_phase_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req = 1'b0, we = 1'b0, ack = 1'b0;
  logic [15:0] ab = '0;
  logic [7:0] wd = '0, bin = '0;
  int sel = 0;
  int checks = 0, errs = 0;
  int cfg_s[3] = '{1, 3, 2};
  int cfg_t[3] = '{15, 15, 0};
  logic [7:0] exp_di[3];
  logic exp_to[3];
  logic [7:0] o_di, o_out;
  logic o_rdy, o_oe, o_strobe, o_to;
  logic [1:0] o_phase;

  always #5 clk = ~clk;

  bus_phase_sequencer_if ia();
  bus_phase_sequencer_if ib();
  bus_phase_sequencer_if ic();

  assign ia.cpu_req = req && sel == 0;
  assign ib.cpu_req = req && sel == 1;
  assign ic.cpu_req = req && sel == 2;
  assign ia.cpu_ab = ab;
  assign ib.cpu_ab = ab;
  assign ic.cpu_ab = ab;
  assign ia.cpu_do = wd;
  assign ib.cpu_do = wd;
  assign ic.cpu_do = wd;
  assign ia.cpu_we = we;
  assign ib.cpu_we = we;
  assign ic.cpu_we = we;
  assign ia.bus_in = bin;
  assign ib.bus_in = bin;
  assign ic.bus_in = bin;
  assign ia.ext_ack = ack;
  assign ib.ext_ack = ack;
  assign ic.ext_ack = ack;

  bus_phase_sequencer #(.SETUP_CYCLES(1), .ACK_TIMEOUT(15)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  bus_phase_sequencer #(.SETUP_CYCLES(3), .ACK_TIMEOUT(15)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  bus_phase_sequencer #(.SETUP_CYCLES(2), .ACK_TIMEOUT(0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ic));

  always_comb begin
    o_di = sel == 0 ? ia.cpu_di : sel == 1 ? ib.cpu_di : ic.cpu_di;
    o_out = sel == 0 ? ia.bus_out : sel == 1 ? ib.bus_out : ic.bus_out;
    o_rdy = sel == 0 ? ia.cpu_rdy : sel == 1 ? ib.cpu_rdy : ic.cpu_rdy;
    o_oe = sel == 0 ? ia.bus_oe : sel == 1 ? ib.bus_oe : ic.bus_oe;
    o_strobe = sel == 0 ? ia.bus_strobe : sel == 1 ? ib.bus_strobe : ic.bus_strobe;
    o_to = sel == 0 ? ia.timeout : sel == 1 ? ib.timeout : ic.timeout;
    o_phase = sel == 0 ? ia.bus_phase : sel == 1 ? ib.bus_phase : ic.bus_phase;
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = 1'b0;
    ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_di[i] = 8'h00;
      exp_to[i] = 1'b0;
    end
  endtask

  // One access: expected per-cycle bus view is derived from phase lengths alone.
  // d = DATA cycle (0-based) in which ack is raised, -1 = never.
  task automatic run_txn(input int s, input logic [15:0] a, input logic [7:0] dw, input logic w,
                         input logic [7:0] b, input int d, input bit hold, input bit noise, input int abort);
    int sc, tm, n_data, len, idx;
    bit acked, in_data;
    logic [1:0] ep;
    logic eo, es, er;
    logic [7:0] eb;
    sc = cfg_s[s];
    tm = cfg_t[s];
    acked = d >= 0 && (tm == 0 || d < tm);
    n_data = acked ? d + 1 : tm;
    len = 2 * sc + n_data + 1;
    if (!w) exp_di[s] = acked ? b : 8'hFF;
    if (!acked) exp_to[s] = 1'b1;
    @(negedge clk);
    sel = s;
    ab = a;
    wd = dw;
    we = w;
    bin = b;
    req = 1'b1;
    ack = 1'b0;
    #1;
    checks++;
    if (o_phase !== 2'b00 || o_rdy !== 1'b0)
      $display("FAIL idle_before_req dut=%0d got phase=%b rdy=%b want phase=00 rdy=0", s, o_phase, o_rdy);
    if (o_phase !== 2'b00 || o_rdy !== 1'b0) errs++;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (!hold) req = 1'b0;
      if (k == abort) begin
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({o_di, o_rdy, o_out, o_oe, o_phase, o_strobe, o_to} !== 22'd0) begin
          errs++;
          $display("FAIL reset_mid_access dut=%0d got di=%h rdy=%b out=%h oe=%b phase=%b strobe=%b to=%b want all zero",
                   s, o_di, o_rdy, o_out, o_oe, o_phase, o_strobe, o_to);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
          exp_di[i] = 8'h00;
          exp_to[i] = 1'b0;
        end
        return;
      end
      in_data = k >= 2 * sc && k < 2 * sc + n_data;
      idx = k - 2 * sc;
      ep = k < sc ? 2'b01 : k < 2 * sc ? 2'b10 : in_data ? 2'b11 : 2'b00;
      eo = k < 2 * sc || (in_data && w);
      es = in_data;
      er = k == len - 1;
      eb = k < sc ? a[7:0] : k < 2 * sc ? a[15:8] : dw;
      checks++;
      if ({o_phase, o_oe, o_strobe, o_rdy} !== {ep, eo, es, er} || (eo && o_out !== eb)) begin
        errs++;
        $display("FAIL phase_cycle dut=%0d k=%0d got phase=%b oe=%b strobe=%b rdy=%b out=%h want phase=%b oe=%b strobe=%b rdy=%b out=%h",
                 s, k, o_phase, o_oe, o_strobe, o_rdy, o_out, ep, eo, es, er, eb);
      end
      if (er) begin
        checks++;
        if (o_di !== exp_di[s] || o_to !== exp_to[s]) begin
          errs++;
          $display("FAIL completion dut=%0d got di=%h timeout=%b want di=%h timeout=%b", s, o_di, o_to, exp_di[s], exp_to[s]);
        end
      end
      ack = in_data ? idx == d : (noise && k < 2 * sc) ? 1'($urandom) : 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checks++;
      if ({o_di, o_rdy, o_out, o_oe, o_phase, o_strobe, o_to} !== 22'd0) begin
        errs++;
        $display("FAIL reset_state dut=%0d got di=%h rdy=%b out=%h oe=%b phase=%b strobe=%b to=%b want all zero",
                 s, o_di, o_rdy, o_out, o_oe, o_phase, o_strobe, o_to);
      end
    end
  endtask

  task automatic test_read_write();
    run_txn(0, 16'h1234, 8'h00, 1'b0, 8'h5A, 1, 1'b0, 1'b0, -1);
    run_txn(0, 16'hABCD, 8'h77, 1'b1, 8'h99, 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_timeout();
    run_txn(0, 16'h4321, 8'h00, 1'b0, 8'h11, -1, 1'b0, 1'b0, -1);
    run_txn(0, 16'h0102, 8'h33, 1'b1, 8'h22, 2, 1'b0, 1'b0, -1);
    run_txn(0, 16'h0304, 8'h00, 1'b0, 8'h44, 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_ack_terminal();
    do_reset();
    run_txn(0, 16'h0F0F, 8'h00, 1'b0, 8'h3C, 14, 1'b0, 1'b0, -1);
    run_txn(0, 16'hF0F0, 8'h00, 1'b0, 8'h3D, 15, 1'b0, 1'b0, -1);
  endtask

  task automatic test_reset_mid();
    run_txn(0, 16'h5555, 8'hAA, 1'b1, 8'h00, 10, 1'b0, 1'b0, 3);
    run_txn(0, 16'h6666, 8'h00, 1'b0, 8'hC3, 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_no_timeout();
    run_txn(2, 16'h7E81, 8'h00, 1'b0, 8'h96, 25, 1'b0, 1'b1, -1);
  endtask

  task automatic test_back_to_back();
    run_txn(1, 16'hBEEF, 8'h12, 1'b1, 8'h00, 0, 1'b1, 1'b0, -1);
    run_txn(1, 16'hCAFE, 8'h00, 1'b0, 8'hE7, 1, 1'b1, 1'b0, -1);
    run_txn(1, 16'hD00D, 8'h00, 1'b0, 8'h81, 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_random();
    int s, d;
    for (int i = 0; i < 18; i++) begin
      s = int'($urandom_range(0, 2));
      d = cfg_t[s] == 0 ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 18)) - 1;
      run_txn(s, 16'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), d, 1'b0, 1'b1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_read_write();
    test_timeout();
    test_ack_terminal();
    test_reset_mid();
    test_no_timeout();
    test_back_to_back();
    test_random();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end
endmodule
